// File: rtl/eth_rx_frame_writer.sv
// Packs an Ethernet RX byte stream little-endian into 32-bit words and writes each frame, then its
// length/status header, into a circular buffer in on-chip RAM; frames that do not fit are dropped.
module eth_rx_frame_writer #(
  parameter int ADDR_W          = 11,
  parameter int MAX_FRAME_BYTES = 1536,
  parameter int CNT_W           = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_error,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic [ADDR_W-1:0] sw_rd_ptr,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_irq,
  output logic [CNT_W-1:0]  frame_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_HDR   = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [15:0]       MAX_B = 16'(MAX_FRAME_BYTES);

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] hdr_ptr, hdr_ptr_n;
  logic [ADDR_W-1:0] dptr, dptr_n;
  logic [ADDR_W-1:0] wr_ptr_n;
  logic [15:0]       bytes, bytes_n, bytes_inc;
  logic [31:0]       word_q, word_n;
  logic              err_q, err_n;
  logic              ready_q;
  logic              accept;
  logic              start;
  logic              drop;
  logic              fc_inc;
  logic [1:0]        dc_add;
  logic [CNT_W:0]    dc_sum;
  logic              irq_n;

  logic              iss_vld;
  logic [ADDR_W-1:0] iss_addr;
  logic [3:0]        iss_be;
  logic [31:0]       iss_dat;

  // One slot always stays empty so that wr_ptr == sw_rd_ptr unambiguously means "empty".
  function automatic logic writable(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] rd);
    return (a + ONE) != rd;
  endfunction

  assign accept    = in_valid & ready_q;
  assign bytes_inc = bytes + 16'd1;
  assign in_ready  = ready_q;

  always_comb begin
    state_n   = state;
    hdr_ptr_n = hdr_ptr;
    dptr_n    = dptr;
    wr_ptr_n  = wr_ptr;
    bytes_n   = bytes;
    word_n    = word_q;
    err_n     = err_q;
    start     = 1'b0;
    drop      = 1'b0;
    fc_inc    = 1'b0;
    dc_add    = 2'd0;
    irq_n     = 1'b0;
    iss_vld   = 1'b0;
    iss_addr  = dptr;
    iss_be    = 4'hF;
    iss_dat   = word_q;

    case (state)
      S_IDLE: begin
        if (accept && in_sop) start = 1'b1;
      end
      S_DATA: begin
        if (accept) begin
          if (in_sop) begin
            // Missing eop: the unfinished frame is lost and this byte opens a new one.
            dc_add = 2'd1;
            start  = 1'b1;
          end else begin
            bytes_n = bytes_inc;
            word_n[{bytes[1:0], 3'b000} +: 8] = in_data;
            if (bytes_inc > MAX_B) begin
              drop = 1'b1;
            end else if (bytes[1:0] == 2'd3) begin
              if (writable(dptr, sw_rd_ptr)) begin
                iss_vld  = 1'b1;
                iss_addr = dptr;
                iss_be   = 4'hF;
                iss_dat  = {in_data, word_q[23:0]};
                dptr_n   = dptr + ONE;
                if (in_eop) begin
                  state_n = S_FLUSH;
                  err_n   = in_error;
                end
              end else begin
                drop = 1'b1;
              end
            end else if (in_eop) begin
              state_n = S_FLUSH;
              err_n   = in_error;
            end
          end
        end
      end
      S_FLUSH: begin
        if (bytes[1:0] != 2'd0) begin
          if (writable(dptr, sw_rd_ptr)) begin
            iss_vld  = 1'b1;
            iss_addr = dptr;
            iss_dat  = word_q;
            case (bytes[1:0])
              2'd1:    iss_be = 4'h1;
              2'd2:    iss_be = 4'h3;
              default: iss_be = 4'h7;
            endcase
            dptr_n  = dptr + ONE;
            state_n = S_HDR;
          end else begin
            dc_add  = 2'd1;
            state_n = S_IDLE;
          end
        end else begin
          state_n = S_HDR;
        end
      end
      S_HDR: begin
        // Header goes last so software never observes a frame whose data is still in flight.
        iss_vld  = 1'b1;
        iss_addr = hdr_ptr;
        iss_be   = 4'hF;
        iss_dat  = {err_q, 15'd0, bytes};
        wr_ptr_n = dptr;
        fc_inc   = 1'b1;
        irq_n    = 1'b1;
        state_n  = S_IDLE;
      end
      S_DROP: begin
        if (accept && in_eop) begin
          dc_add  = 2'd1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (start) begin
      hdr_ptr_n = wr_ptr;
      dptr_n    = wr_ptr + ONE;
      bytes_n   = 16'd1;
      word_n    = {24'd0, in_data};
      if (!writable(wr_ptr, sw_rd_ptr)) begin
        drop = 1'b1;
      end else if (in_eop) begin
        state_n = S_FLUSH;
        err_n   = in_error;
      end else begin
        state_n = S_DATA;
      end
    end

    if (drop) begin
      if (in_eop) begin
        dc_add  = dc_add + 2'd1;
        state_n = S_IDLE;
      end else begin
        state_n = S_DROP;
      end
    end
  end

  assign dc_sum = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, dc_add};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      hdr_ptr     <= '0;
      dptr        <= '0;
      wr_ptr      <= '0;
      bytes       <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      frame_irq   <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      state     <= state_n;
      hdr_ptr   <= hdr_ptr_n;
      dptr      <= dptr_n;
      wr_ptr    <= wr_ptr_n;
      bytes     <= bytes_n;
      word_q    <= word_n;
      err_q     <= err_n;
      ready_q   <= (state_n != S_FLUSH) && (state_n != S_HDR);
      frame_irq <= irq_n;
      if (fc_inc) frame_count <= frame_count + CNT_W'(1);
      drop_count <= dc_sum[CNT_W] ? {CNT_W{1'b1}} : dc_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_address    <= '0;
      ram_byteenable <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
    end else begin
      ram_write      <= iss_vld;
      ram_chipselect <= iss_vld;
      if (iss_vld) begin
        ram_address    <= iss_addr;
        ram_byteenable <= iss_be;
        ram_writedata  <= iss_dat;
      end
    end
  end

endmodule
